cam_update_ctrl: RTL and testbench

//  Write-side manager for the CAM wrapper. Accepts INSERT/DELETE/FLUSH commands over a

---
 rtl/cam_update_if.sv | 36 +++
 rtl/cam_update_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_cam_update_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_update_if.sv
// cam_update_if
//   Command/response channel between the control-plane side and the CAM
//   update controller. Both directions use valid/ready handshakes.
//   cmd_valid/cmd_ready  command handshake
//   cmd_op               00 INSERT, 01 DELETE, 10 FLUSH, 11 reserved
//   cmd_addr             DELETE target address
//   cmd_patt/cmd_mask    INSERT pattern and mask
//   rsp_valid/rsp_ready  response handshake
//   rsp_ok               1 = command performed
//   rsp_addr             allocated/freed address, else 0
//   master modport: control-plane side, slave modport: controller side.
interface cam_update_if #(
    parameter int AW    = 9,
    parameter int WIDTH = 36
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [AW-1:0]    cmd_addr;
    logic [WIDTH-1:0] cmd_patt;
    logic [WIDTH-1:0] cmd_mask;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_ok;
    logic [AW-1:0]    rsp_addr;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_patt, cmd_mask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_ok, rsp_addr
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_patt, cmd_mask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_ok, rsp_addr
    );
endinterface

// File: rtl/cam_update_ctrl.sv
// cam_update_ctrl
//   Write-side manager for the CAM wrapper. Accepts INSERT/DELETE/FLUSH
//   commands, allocates the lowest free entry for INSERT, drives the CAM
//   write port and keeps an occupancy bitmap. One response per command.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     bus             command/response channel (cam_update_if.slave)
//     wEn/wAddr       CAM write enable and address
//     wPatt/wMask     CAM write pattern and mask
//     used_cnt        number of occupied entries (0..DEPTH)
//     full/empty      used_cnt==DEPTH / used_cnt==0
//   All outputs are registered.
module cam_update_ctrl #(
    parameter int               DEPTH    = 512,
    parameter int               WIDTH    = 36,
    localparam int              AW       = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] DEL_PATT = '1
) (
    input  logic             clk,
    input  logic             rst,
    cam_update_if.slave      bus,
    output logic             wEn,
    output logic [AW-1:0]    wAddr,
    output logic [WIDTH-1:0] wPatt,
    output logic [WIDTH-1:0] wMask,
    output logic [AW:0]      used_cnt,
    output logic             full,
    output logic             empty
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FLUSH, S_RESP} state_e;
    typedef enum logic [1:0] {OP_INSERT = 2'b00, OP_DELETE = 2'b01,
                              OP_FLUSH = 2'b10, OP_RSVD = 2'b11} op_e;

    // DEPTH may not be a power of two, so addresses are range-checked at AW+1 bits
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [DEPTH-1:0] used_map, used_d;
    logic [AW:0]      cnt_d;
    logic             insert_q, insert_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_ok_q, rsp_ok_d;
    logic [AW-1:0]    rsp_addr_q, rsp_addr_d;
    logic             wen_d;
    logic [AW-1:0]    waddr_d;
    logic [WIDTH-1:0] wpatt_d, wmask_d;
    logic             alloc_found;
    logic [AW-1:0]    alloc_idx;
    logic             del_ok;

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_ok    = rsp_ok_q;
    assign bus.rsp_addr  = rsp_addr_q;

    // Priority encoder over the free entries; scanning downwards lets index 0 win
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!used_map[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = AW'(i);
            end
        end
    end

    // A DELETE is only performed on an in-range, currently occupied entry
    always_comb begin
        del_ok = 1'b0;
        if ({1'b0, bus.cmd_addr} < DEPTH_W) begin
            del_ok = used_map[bus.cmd_addr];
        end
    end

    // Next-state and next-output logic; every output register is loaded from here
    always_comb begin
        state_d     = state_q;
        used_d      = used_map;
        cnt_d       = used_cnt;
        insert_d    = insert_q;
        cmd_ready_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_ok_d    = rsp_ok_q;
        rsp_addr_d  = rsp_addr_q;
        wen_d       = 1'b0;
        waddr_d     = wAddr;
        wpatt_d     = wPatt;
        wmask_d     = wMask;

        case (state_q)
            S_IDLE: begin
                if (cmd_ready_q && bus.cmd_valid) begin
                    // Default to a rejection; accepted ops override below
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_ok_d    = 1'b0;
                    rsp_addr_d  = '0;
                    case (bus.cmd_op)
                        OP_INSERT: begin
                            if (alloc_found) begin
                                state_d     = S_WRITE;
                                rsp_valid_d = 1'b0;
                                wen_d       = 1'b1;
                                waddr_d     = alloc_idx;
                                wpatt_d     = bus.cmd_patt;
                                wmask_d     = bus.cmd_mask;
                                insert_d    = 1'b1;
                            end
                        end
                        OP_DELETE: begin
                            if (del_ok) begin
                                state_d     = S_WRITE;
                                rsp_valid_d = 1'b0;
                                wen_d       = 1'b1;
                                waddr_d     = bus.cmd_addr;
                                wpatt_d     = DEL_PATT;
                                wmask_d     = '0;
                                insert_d    = 1'b0;
                            end
                        end
                        OP_FLUSH: begin
                            state_d     = S_FLUSH;
                            rsp_valid_d = 1'b0;
                            wen_d       = 1'b1;
                            waddr_d     = '0;
                            wpatt_d     = DEL_PATT;
                            wmask_d     = '0;
                        end
                        default: ;
                    endcase
                end
            end
            S_WRITE: begin
                // Occupancy changes as the single write cycle completes
                used_d[wAddr] = insert_q;
                cnt_d         = insert_q ? used_cnt + CNT_ONE : used_cnt - CNT_ONE;
                state_d       = S_RESP;
                rsp_valid_d   = 1'b1;
                rsp_ok_d      = 1'b1;
                rsp_addr_d    = wAddr;
            end
            S_FLUSH: begin
                // wAddr doubles as the sweep counter
                if (wAddr == LAST_ADDR) begin
                    used_d      = '0;
                    cnt_d       = '0;
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_ok_d    = 1'b1;
                    rsp_addr_d  = '0;
                end else begin
                    wen_d   = 1'b1;
                    waddr_d = wAddr + ADDR_ONE;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_ok_d    = 1'b0;
                    rsp_addr_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // cmd_ready is registered, so it is asserted for any cycle spent in IDLE
        if (state_d == S_IDLE) begin
            cmd_ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            used_map    <= '0;
            used_cnt    <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            insert_q    <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_ok_q    <= 1'b0;
            rsp_addr_q  <= '0;
            wEn         <= 1'b0;
            wAddr       <= '0;
            wPatt       <= '0;
            wMask       <= '0;
        end else begin
            state_q     <= state_d;
            used_map    <= used_d;
            used_cnt    <= cnt_d;
            full        <= (cnt_d == DEPTH_W);
            empty       <= (cnt_d == '0);
            insert_q    <= insert_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ok_q    <= rsp_ok_d;
            rsp_addr_q  <= rsp_addr_d;
            wEn         <= wen_d;
            wAddr       <= waddr_d;
            wPatt       <= wpatt_d;
            wMask       <= wmask_d;
        end
    end

endmodule

// File: tb/tb_cam_update_ctrl.sv
// tb_cam_update_ctrl
//   Drives two controller instances (DEPTH=8 and DEPTH=6, both AW=3) one at a
//   time through directed and random command sequences, comparing every
//   cycle of each transaction against an occupancy model of the CAM.
module tb_cam_update_ctrl;

    localparam int          WIDTH = 36;
    localparam logic [35:0] DEL   = '1;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_addr;
    logic [35:0] cmd_patt;
    logic [35:0] cmd_mask;
    logic        rsp_ready;

    logic        wEn8, wEn6, full8, full6, empty8, empty6;
    logic [2:0]  wAddr8, wAddr6;
    logic [35:0] wPatt8, wPatt6, wMask8, wMask6;
    logic [3:0]  used8, used6;

    int n_assert = 0;
    int n_fail   = 0;

    bit model_used [8];
    int model_cnt;
    int model_depth;

    always #5 clk = ~clk;

    cam_update_if #(.AW(3), .WIDTH(WIDTH)) bus8 ();
    cam_update_if #(.AW(3), .WIDTH(WIDTH)) bus6 ();

    assign bus8.cmd_valid = cmd_valid & ~sel;
    assign bus6.cmd_valid = cmd_valid & sel;
    assign bus8.rsp_ready = rsp_ready & ~sel;
    assign bus6.rsp_ready = rsp_ready & sel;
    assign bus8.cmd_op    = cmd_op;
    assign bus6.cmd_op    = cmd_op;
    assign bus8.cmd_addr  = cmd_addr;
    assign bus6.cmd_addr  = cmd_addr;
    assign bus8.cmd_patt  = cmd_patt;
    assign bus6.cmd_patt  = cmd_patt;
    assign bus8.cmd_mask  = cmd_mask;
    assign bus6.cmd_mask  = cmd_mask;

    cam_update_ctrl #(.DEPTH(8), .WIDTH(WIDTH)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8),
        .wEn(wEn8), .wAddr(wAddr8), .wPatt(wPatt8), .wMask(wMask8),
        .used_cnt(used8), .full(full8), .empty(empty8)
    );

    cam_update_ctrl #(.DEPTH(6), .WIDTH(WIDTH)) dut6 (
        .clk(clk), .rst(rst), .bus(bus6),
        .wEn(wEn6), .wAddr(wAddr6), .wPatt(wPatt6), .wMask(wMask6),
        .used_cnt(used6), .full(full6), .empty(empty6)
    );

    wire        o_cmd_ready = sel ? bus6.cmd_ready : bus8.cmd_ready;
    wire        o_rsp_valid = sel ? bus6.rsp_valid : bus8.rsp_valid;
    wire        o_rsp_ok    = sel ? bus6.rsp_ok    : bus8.rsp_ok;
    wire [2:0]  o_rsp_addr  = sel ? bus6.rsp_addr  : bus8.rsp_addr;
    wire        o_wEn       = sel ? wEn6   : wEn8;
    wire [2:0]  o_wAddr     = sel ? wAddr6 : wAddr8;
    wire [35:0] o_wPatt     = sel ? wPatt6 : wPatt8;
    wire [35:0] o_wMask     = sel ? wMask6 : wMask8;
    wire [3:0]  o_used      = sel ? used6  : used8;
    wire        o_full      = sel ? full6  : full8;
    wire        o_empty     = sel ? empty6 : empty8;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resetModel();
        for (int i = 0; i < 8; i++) model_used[i] = 1'b0;
        model_cnt = 0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_cmd_ready"}, o_cmd_ready, 0);
        checkOutput({tag, "_rsp_valid"}, o_rsp_valid, 0);
        checkOutput({tag, "_rsp_ok"}, o_rsp_ok, 0);
        checkOutput({tag, "_rsp_addr"}, o_rsp_addr, 0);
        checkOutput({tag, "_wEn"}, o_wEn, 0);
        checkOutput({tag, "_wAddr"}, o_wAddr, 0);
        checkOutput({tag, "_wPatt"}, o_wPatt, 0);
        checkOutput({tag, "_wMask"}, o_wMask, 0);
        checkOutput({tag, "_used_cnt"}, o_used, 0);
        checkOutput({tag, "_empty"}, o_empty, 1);
        checkOutput({tag, "_full"}, o_full, 0);
    endtask

    task automatic waitReady();
        int n = 0;
        while (o_cmd_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checkOutput("cmd_ready_wait", o_cmd_ready, 1);
    endtask

    // Issues one command, follows it cycle by cycle and consumes the response
    task automatic applyStimulus(input logic [1:0] op, input logic [2:0] addr,
                                 input logic [35:0] patt, input logic [35:0] mask,
                                 input int stall);
        bit exp_ok = 1'b0;
        int target = 0;
        waitReady();
        case (op)
            2'd0: for (int i = model_depth - 1; i >= 0; i--)
                      if (!model_used[i]) begin exp_ok = 1'b1; target = i; end
            2'd1: if (int'(addr) < model_depth && model_used[addr]) begin
                      exp_ok = 1'b1;
                      target = int'(addr);
                  end
            2'd2: exp_ok = 1'b1;
            default: exp_ok = 1'b0;
        endcase
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_patt  = patt;
        cmd_mask  = mask;
        step();
        cmd_valid = 1'b0;
        cmd_patt  = 36'($urandom());
        cmd_mask  = 36'($urandom());
        checkOutput("cmd_ready_busy", o_cmd_ready, 0);
        if (exp_ok && op != 2'd2) begin
            checkOutput("write_wEn", o_wEn, 1);
            checkOutput("write_wAddr", o_wAddr, 64'(target));
            checkOutput("write_wPatt", o_wPatt, (op == 2'd0) ? patt : DEL);
            checkOutput("write_wMask", o_wMask, (op == 2'd0) ? mask : 36'd0);
            checkOutput("write_rsp_valid", o_rsp_valid, 0);
            step();
            model_used[target] = (op == 2'd0);
            model_cnt += (op == 2'd0) ? 1 : -1;
        end else if (exp_ok) begin
            for (int i = 0; i < model_depth; i++) begin
                checkOutput("flush_wEn", o_wEn, 1);
                checkOutput("flush_wAddr", o_wAddr, 64'(i));
                checkOutput("flush_wPatt", o_wPatt, DEL);
                checkOutput("flush_wMask", o_wMask, 0);
                checkOutput("flush_rsp_valid", o_rsp_valid, 0);
                step();
            end
            resetModel();
            target = 0;
        end
        checkOutput("rsp_wEn", o_wEn, 0);
        checkOutput("rsp_valid", o_rsp_valid, 1);
        checkOutput("rsp_ok", o_rsp_ok, 64'(exp_ok));
        checkOutput("rsp_addr", o_rsp_addr, exp_ok ? 64'(target) : 64'd0);
        checkOutput("used_cnt", o_used, 64'(model_cnt));
        checkOutput("full", o_full, 64'(model_cnt == model_depth));
        checkOutput("empty", o_empty, 64'(model_cnt == 0));
        for (int s = 0; s < stall; s++) begin
            step();
            checkOutput("stall_rsp_valid", o_rsp_valid, 1);
            checkOutput("stall_rsp_ok", o_rsp_ok, 64'(exp_ok));
            checkOutput("stall_rsp_addr", o_rsp_addr, exp_ok ? 64'(target) : 64'd0);
            checkOutput("stall_cmd_ready", o_cmd_ready, 0);
            checkOutput("stall_wEn", o_wEn, 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checkOutput("post_rsp_valid", o_rsp_valid, 0);
        checkOutput("post_cmd_ready", o_cmd_ready, 1);
    endtask

    task automatic randomCommands(input int count);
        int r;
        logic [1:0] op;
        for (int n = 0; n < count; n++) begin
            r = $urandom_range(0, 19);
            if (r < 10)      op = 2'd0;
            else if (r < 17) op = 2'd1;
            else if (r < 18) op = 2'd2;
            else             op = 2'd3;
            applyStimulus(op, 3'($urandom_range(0, 7)),
                          {4'($urandom()), 32'($urandom())},
                          {4'($urandom()), 32'($urandom())},
                          $urandom_range(0, 3));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sel = 1'b0; rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 3'd0;
        cmd_patt = '0; cmd_mask = '0; rsp_ready = 1'b0;
        model_depth = 8;
        resetModel();

        $display("[TB] power-on reset");
        #2 rst = 1'b1;
        #1 checkReset("por");
        step();
        step();
        rst = 1'b0;

        $display("[TB] insert three patterns");
        applyStimulus(2'd0, 3'd0, 36'h1, 36'hF_0000_000F, 0);
        applyStimulus(2'd0, 3'd0, 36'h2, 36'h0_FFFF_0000, 1);
        applyStimulus(2'd0, 3'd0, 36'h3, 36'h0, 0);

        $display("[TB] delete and reuse");
        applyStimulus(2'd1, 3'd1, 36'h0, 36'h0, 0);
        applyStimulus(2'd0, 3'd0, 36'h4, 36'h5, 0);
        applyStimulus(2'd1, 3'd5, 36'h0, 36'h0, 0);

        $display("[TB] fill to full and overflow");
        for (int i = 0; i < 5; i++) applyStimulus(2'd0, 3'd0, 36'(i + 5), 36'hA, 0);
        applyStimulus(2'd0, 3'd0, 36'hBAD, 36'h0, 5);
        applyStimulus(2'd3, 3'd2, 36'h0, 36'h0, 0);

        $display("[TB] flush with four entries used");
        applyStimulus(2'd1, 3'd0, 36'h0, 36'h0, 0);
        applyStimulus(2'd1, 3'd2, 36'h0, 36'h0, 0);
        applyStimulus(2'd1, 3'd4, 36'h0, 36'h0, 0);
        applyStimulus(2'd1, 3'd6, 36'h0, 36'h0, 0);
        applyStimulus(2'd2, 3'd0, 36'h0, 36'h0, 2);
        applyStimulus(2'd0, 3'd0, 36'h77, 36'h1, 0);

        $display("[TB] random commands, DEPTH=8");
        randomCommands(40);

        $display("[TB] reset during flush");
        applyStimulus(2'd0, 3'd0, 36'h11, 36'h0, 0);
        waitReady();
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        checkOutput("midflush_wEn", o_wEn, 1);
        rst = 1'b1;
        #1 checkReset("midflush");
        resetModel();
        step();
        rst = 1'b0;

        $display("[TB] DEPTH=6 instance");
        sel = 1'b1;
        model_depth = 6;
        rst = 1'b1;
        #1 checkReset("d6");
        step();
        rst = 1'b0;
        applyStimulus(2'd1, 3'd7, 36'h0, 36'h0, 0);
        applyStimulus(2'd1, 3'd6, 36'h0, 36'h0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(2'd0, 3'd0, 36'(i + 32), 36'h3, 0);
        applyStimulus(2'd0, 3'd0, 36'h99, 36'h0, 1);
        applyStimulus(2'd1, 3'd5, 36'h0, 36'h0, 0);
        applyStimulus(2'd1, 3'd5, 36'h0, 36'h0, 0);
        randomCommands(20);
        applyStimulus(2'd2, 3'd0, 36'h0, 36'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
